sw_transport_stream: RTL and testbench



---
 rtl/sw_transport_stream_if.sv | 11 +
 rtl/sw_transport_stream.sv | 147 ++++++++++++++
 tb/tb_sw_transport_stream.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/sw_transport_stream_if.sv
// Stream bundle for sw_transport_stream: head-of-queue word, valid and ready.
interface sw_transport_stream_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/sw_transport_stream.sv
// sw_transport_stream: synchronises and debounces a switch bus, keeps codes in
// [CODE_MIN, CODE_MAX], queues them in a small FIFO and presents them on a
// valid/ready stream.
// Optional build macro: SW_TRANSPORT_PARITY_EN puts the XOR of the code bits
// into the word MSB; without it the MSB is always 0 and no parity logic exists.
module sw_transport_stream #(
  parameter int SW_W       = 4,
  parameter int DATA_W     = 8,
  parameter int CODE_MIN   = 1,
  parameter int CODE_MAX   = 8,
  parameter int DEB_CYC    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SW_W-1:0]               sw,
  sw_transport_stream_if.master         tx,
  output logic [SW_W-1:0]               last_code,
  output logic [7:0]                    drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [SW_W-1:0]   sync_q;
  logic [SW_W-1:0]   sw_s;
  logic [SW_W-1:0]   cand;
  logic [SW_W-1:0]   committed;
  logic [SW_W-1:0]   commit_code;
  logic [7:0]        stab;
  logic [7:0]        stab_nxt;
  logic              commit_evt;

  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic              full;
  logic              empty;
  logic              drop;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;

  // Two-flop synchroniser for the asynchronous switch inputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      sync_q <= '0;
      sw_s   <= '0;
    end else begin
      sync_q <= sw;
      sw_s   <= sync_q;
    end
  end

  // Next value of the stability counter; saturates at DEB_CYC.
  always_comb begin
    // NOTE: assigning a default first keeps every path covered, so no latch.
    stab_nxt = stab;
    if (sw_s != cand)
      stab_nxt = '0;
    else if (stab < 8'(DEB_CYC))
      stab_nxt = stab + 8'd1;
  end

  // Debounce: commit the candidate once it has been stable for DEB_CYC cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand        <= '0;
      stab        <= '0;
      committed   <= '0;
      commit_evt  <= 1'b0;
      commit_code <= '0;
    end else begin
      commit_evt <= 1'b0;
      stab       <= stab_nxt;
      if (sw_s != cand)
        cand <= sw_s;
      if ((sw_s == cand) && (stab_nxt == 8'(DEB_CYC)) && (cand != committed)) begin
        committed   <= cand;
        commit_evt  <= 1'b1;
        commit_code <= cand;
      end
    end
  end

  assign push_req = commit_evt
                 && (commit_code >= SW_W'(CODE_MIN))
                 && (commit_code <= SW_W'(CODE_MAX));

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign pop     = !empty && tx.out_ready;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  // Stored word: code in the low bits, zero pad, optional parity in the MSB.
  always_comb begin
    word             = '0;
    word[SW_W-1:0]   = commit_code;
`ifdef SW_TRANSPORT_PARITY_EN
    word[DATA_W-1]   = ^commit_code;
`endif
  end

  // Queue storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; the read side is
    // gated by the occupancy count, so stale entries are never visible.
    if (push_ok)
      mem[wr_ptr] <= word;
  end

  // Queue pointers, occupancy and status counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      drop_cnt  <= '0;
      last_code <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (drop && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
      if (push_req)
        last_code <= commit_code;
    end
  end

  assign tx.out_valid = !empty;
  assign tx.out_data  = empty ? '0 : mem[rd_ptr];
  assign fifo_level   = count;

endmodule

// File: tb/tb_sw_transport_stream.sv
// Directed self-checking bench for sw_transport_stream (default parameters).
// Expected words follow SW_TRANSPORT_PARITY_EN when it is defined for the bench.
module tb_sw_transport_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic [3:0] last_code;
  logic [7:0] drop_cnt;
  logic [2:0] fifo_level;
  int         total = 0;
  int         bad   = 0;

  sw_transport_stream_if #(.DATA_W(8)) bus ();

  sw_transport_stream dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .tx         (bus),
    .last_code  (last_code),
    .drop_cnt   (drop_cnt),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_word(input logic [3:0] c);
    logic [7:0] w;
    w = {4'b0000, c};
`ifdef SW_TRANSPORT_PARITY_EN
    w[7] = ^c;
`endif
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance n cycles, counting valid cycles and capturing the first word seen.
  task automatic watch(input int n, output int vcnt, output logic [7:0] d);
    vcnt = 0;
    d    = '0;
    repeat (n) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (vcnt == 0) d = bus.out_data;
        vcnt++;
      end
    end
  endtask

  initial begin
    int         v1, v2, vsum;
    logic [7:0] d1, d2;

    rst = 1'b1;
    sw  = 4'd0;
    bus.out_ready = 1'b0;

    // Reset state
    tick(3);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data",  32'(bus.out_data),  32'd0);
    check("rst_last",  32'(last_code),     32'd0);
    check("rst_drop",  32'(drop_cnt),      32'd0);
    check("rst_level", 32'(fifo_level),    32'd0);
    rst = 1'b0;
    tick(1);

    // Basic latency: word appears after edge E1+7
    sw = 4'd5;
    bus.out_ready = 1'b1;
    tick(7);
    check("lat_early_valid", 32'(bus.out_valid), 32'd0);
    tick(1);
    check("lat_valid", 32'(bus.out_valid), 32'd1);
    check("lat_data",  32'(bus.out_data),  32'(exp_word(4'd5)));
    check("lat_level", 32'(fifo_level),    32'd1);
    check("lat_last",  32'(last_code),     32'd5);
    tick(1);
    check("lat_popped", 32'(bus.out_valid), 32'd0);

    // Glitch rejection: 0 commits silently, then 3 held for 4 cycles
    sw = 4'd0;
    watch(12, v1, d1);
    sw = 4'd3;
    watch(4, v2, d2);
    vsum = v1 + v2;
    sw = 4'd0;
    watch(12, v1, d1);
    vsum += v1;
    check("glitch_nvalid", 32'(vsum),      32'd0);
    check("glitch_last",   32'(last_code), 32'd5);

    // Boundary: 3 held exactly DEB_CYC+1 cycles commits once
    sw = 4'd3;
    watch(5, v1, d1);
    sw = 4'd0;
    watch(12, v2, d2);
    check("deb_edge_nvalid", 32'(v1 + v2), 32'd1);
    check("deb_edge_data",   32'(d2),      32'(exp_word(4'd3)));
    check("deb_edge_last",   32'(last_code), 32'd3);

    // Range filter: 9 and 15 rejected, 8 accepted
    sw = 4'd9;
    watch(10, v1, d1);
    vsum = v1;
    sw = 4'd15;
    watch(10, v1, d1);
    vsum += v1;
    check("range_out_nvalid", 32'(vsum),      32'd0);
    check("range_out_last",   32'(last_code), 32'd3);
    sw = 4'd8;
    watch(10, v1, d1);
    check("range_in_nvalid", 32'(v1),        32'd1);
    check("range_in_data",   32'(d1),        32'(exp_word(4'd8)));
    check("range_in_last",   32'(last_code), 32'd8);

    // Overflow: six codes into a four-entry queue with no consumer
    bus.out_ready = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      sw = 4'(c);
      tick(10);
    end
    check("ovf_level", 32'(fifo_level),    32'd4);
    check("ovf_drop",  32'(drop_cnt),      32'd2);
    check("ovf_last",  32'(last_code),     32'd6);
    check("ovf_valid", 32'(bus.out_valid), 32'd1);
    check("ovf_head",  32'(bus.out_data),  32'(exp_word(4'd1)));
    bus.out_ready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      tick(1);
      check($sformatf("ovf_drain_valid%0d", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("ovf_drain_data%0d", i),  32'(bus.out_data),  32'(exp_word(4'(i))));
    end
    tick(1);
    check("ovf_empty_valid", 32'(bus.out_valid), 32'd0);
    check("ovf_empty_level", 32'(fifo_level),    32'd0);

    // Simultaneous push and pop on a full queue
    bus.out_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      sw = 4'(c);
      tick(10);
    end
    check("pp_full_level", 32'(fifo_level), 32'd4);
    sw = 4'd7;
    tick(7);
    check("pp_pre_level", 32'(fifo_level), 32'd4);
    check("pp_pre_drop",  32'(drop_cnt),   32'd2);
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
    check("pp_level", 32'(fifo_level),   32'd4);
    check("pp_drop",  32'(drop_cnt),     32'd2);
    check("pp_last",  32'(last_code),    32'd7);
    check("pp_head",  32'(bus.out_data), 32'(exp_word(4'd2)));
    tick(2);
    check("pp_stall_head", 32'(bus.out_data), 32'(exp_word(4'd2)));
    bus.out_ready = 1'b1;
    tick(1);
    check("pp_drain3", 32'(bus.out_data), 32'(exp_word(4'd3)));
    tick(1);
    check("pp_drain4", 32'(bus.out_data), 32'(exp_word(4'd4)));
    tick(1);
    check("pp_drain7", 32'(bus.out_data), 32'(exp_word(4'd7)));
    tick(1);
    check("pp_empty", 32'(bus.out_valid), 32'd0);

    // Reset mid-operation: three queued entries and a debounce in progress
    bus.out_ready = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      sw = 4'(c);
      tick(10);
    end
    check("mid_level", 32'(fifo_level), 32'd3);
    sw = 4'd5;
    tick(4);
    rst = 1'b1;
    tick(1);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_data",  32'(bus.out_data),  32'd0);
    check("mid_rst_last",  32'(last_code),     32'd0);
    check("mid_rst_drop",  32'(drop_cnt),      32'd0);
    check("mid_rst_level", 32'(fifo_level),    32'd0);
    rst = 1'b0;
    sw  = 4'd2;
    bus.out_ready = 1'b1;
    watch(12, v1, d1);
    check("post_rst_nvalid", 32'(v1),        32'd1);
    check("post_rst_data",   32'(d1),        32'(exp_word(4'd2)));
    check("post_rst_last",   32'(last_code), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
